spi_slave_rx: RTL and testbench

SPI_SLAVE_RX -- requirements
Module: spi_slave_rx

---
 rtl/spi_pkg.sv | 13 +
 rtl/spi_sync_edge.sv | 31 +++
 rtl/spi_slave_rx.sv | 114 +++++++++++
 tb/tb_spi_slave_rx.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared state encoding and frame constants for the SPI slave receiver
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    END   = 2'd2
  } state_t;

  localparam int BITS_PER_FRAME = 8;
  localparam int CNT_W          = 4;

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-flop synchronizer with history flop and edge detect
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic q_hist,
  output logic fall,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync   <= {SYNC_STAGES{RESET_VAL}};
      q_hist <= RESET_VAL;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], d};
      q_hist <= sync[SYNC_STAGES-1];
    end
  end

  assign q    = sync[SYNC_STAGES-1];
  assign fall = ~q & q_hist;
  assign rise = q & ~q_hist;

endmodule

// File: rtl/spi_slave_rx.sv
// rtl/spi_slave_rx.sv - CPOL=0 SPI slave: byte receive, word pairing, reply shift-out
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sclk,
  input  logic        mosi,
  input  logic        cs,
  output logic        miso,
  input  logic [7:0]  tx_byte,
  output logic [7:0]  rx_byte,
  output logic        byte_valid,
  output logic [15:0] rx_word,
  output logic        rx_valid,
  output logic        frame_err
);

  logic sclk_q, sclk_hist, sclk_fall, sclk_rise;
  logic mosi_q, mosi_hist, mosi_fall, mosi_rise;
  logic cs_q, cs_hist, cs_fall, cs_rise;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk (
    .clk(clk), .rst_n(rst_n), .d(sclk),
    .q(sclk_q), .q_hist(sclk_hist), .fall(sclk_fall), .rise(sclk_rise)
  );
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi (
    .clk(clk), .rst_n(rst_n), .d(mosi),
    .q(mosi_q), .q_hist(mosi_hist), .fall(mosi_fall), .rise(mosi_rise)
  );
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs (
    .clk(clk), .rst_n(rst_n), .d(cs),
    .q(cs_q), .q_hist(cs_hist), .fall(cs_fall), .rise(cs_rise)
  );

  logic unused_ok;
  assign unused_ok = &{1'b0, sclk_q, sclk_hist, sclk_rise, mosi_q, mosi_fall, mosi_rise, cs_q, cs_hist};

  // The cs pipeline resets to idle-high; until real input has flushed through it, a
  // low cs at release would look like a fresh fall, so starts are held off that long.
  logic [SYNC_STAGES:0] warm;
  logic                 start;

  state_t           state, state_n;
  logic [7:0]       tx_shift, rx_shift, rx_byte_q, low_hold;
  logic [15:0]      rx_word_q;
  logic [CNT_W-1:0] bit_cnt;
  logic             phase, good;

  assign start = cs_fall & warm[SYNC_STAGES];

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = SHIFT;
      SHIFT:   if (cs_rise) state_n = END;
      END:     state_n = start ? SHIFT : IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign good       = (state == END) && (bit_cnt == CNT_W'(BITS_PER_FRAME));
  assign byte_valid = good;
  assign rx_valid   = good & phase;
  assign frame_err  = (state == END) & ~good;
  assign rx_byte    = good ? rx_shift : rx_byte_q;
  assign rx_word    = rx_valid ? {rx_shift, low_hold} : rx_word_q;
  assign miso       = (state == SHIFT) & tx_shift[7];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      warm      <= '0;
      state     <= IDLE;
      tx_shift  <= '0;
      rx_shift  <= '0;
      rx_byte_q <= '0;
      low_hold  <= '0;
      rx_word_q <= '0;
      bit_cnt   <= '0;
      phase     <= 1'b0;
    end else begin
      warm  <= {warm[SYNC_STAGES-1:0], 1'b1};
      state <= state_n;

      if (state_n == SHIFT && state != SHIFT) begin
        tx_shift <= tx_byte;
        rx_shift <= '0;
        bit_cnt  <= '0;
      end else if (state == SHIFT && sclk_fall) begin
        // mosi history lines up with the last high sclk sample
        rx_shift <= {rx_shift[6:0], mosi_hist};
        tx_shift <= {tx_shift[6:0], 1'b0};
        if (bit_cnt != '1) bit_cnt <= bit_cnt + 1'b1;
      end

      if (state == END) begin
        if (!good) begin
          phase <= 1'b0;
        end else if (!phase) begin
          rx_byte_q <= rx_shift;
          low_hold  <= rx_shift;
          phase     <= 1'b1;
        end else begin
          rx_byte_q <= rx_shift;
          rx_word_q <= {rx_shift, low_hold};
          phase     <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_rx.sv
// tb/tb_spi_slave_rx.sv - scoreboard bench for spi_slave_rx
module tb_spi_slave_rx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sclk, mosi, cs, miso;
  logic [7:0]  tx_byte, rx_byte;
  logic        byte_valid, rx_valid, frame_err;
  logic [15:0] rx_word;

  int n_checks = 0;
  int n_pass   = 0;
  int n_err_seen = 0;

  logic [7:0]  byte_q[$];
  logic [15:0] word_q[$];
  int          err_q[$];
  logic        exp_phase;
  logic [7:0]  exp_low;

  spi_slave_rx #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .mosi(mosi), .cs(cs), .miso(miso),
    .tx_byte(tx_byte), .rx_byte(rx_byte), .byte_valid(byte_valid),
    .rx_word(rx_word), .rx_valid(rx_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (byte_valid) begin
        if (byte_q.size() != 0) check("rx_byte", {24'd0, rx_byte}, {24'd0, byte_q.pop_front()});
        else check("byte_valid_unexpected", {31'd0, byte_valid}, 32'd0);
      end
      if (rx_valid) begin
        if (word_q.size() != 0) check("rx_word", {16'd0, rx_word}, {16'd0, word_q.pop_front()});
        else check("rx_valid_unexpected", {31'd0, rx_valid}, 32'd0);
      end
      if (frame_err) begin
        n_err_seen++;
        if (err_q.size() != 0) void'(err_q.pop_front());
        else check("frame_err_unexpected", {31'd0, frame_err}, 32'd0);
      end
    end
  end

  task automatic spi_frame(input logic [7:0] data, input int nbits, input logic [7:0] tx,
                           input bit short_gap);
    logic [7:0] d;
    logic [7:0] got;
    d = data;
    got = '0;
    tx_byte = tx;
    repeat (5) @(posedge clk);
    cs = 1'b0;
    mosi = d[7];
    repeat (50) @(posedge clk);
    for (int i = 0; i < nbits; i++) begin
      got = {got[6:0], miso};
      sclk = 1'b1;
      if (i == 3) tx_byte = ~tx;
      repeat (50) @(posedge clk);
      sclk = 1'b0;
      d = d << 1;
      mosi = d[7];
      repeat (50) @(posedge clk);
    end
    if (nbits == 8) begin
      byte_q.push_back(data);
      if (exp_phase) word_q.push_back({data, exp_low});
      else exp_low = data;
      exp_phase = ~exp_phase;
      check("miso_reply", {24'd0, got}, {24'd0, tx});
    end else begin
      err_q.push_back(1);
      exp_phase = 1'b0;
    end
    cs = 1'b1;
    if (short_gap) @(posedge clk);
    else repeat (20) @(posedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cs = 1'b1; sclk = 1'b0; mosi = 1'b0; tx_byte = 8'h00;
    exp_phase = 1'b0; exp_low = 8'h00;
    repeat (5) @(posedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("reset_rx_byte", {24'd0, rx_byte}, 32'd0);
    check("reset_rx_word", {16'd0, rx_word}, 32'd0);
    check("reset_miso", {31'd0, miso}, 32'd0);
    check("reset_pulses", {29'd0, byte_valid, rx_valid, frame_err}, 32'd0);

    spi_frame(8'h34, 8, 8'hA5, 1'b1);
    spi_frame(8'h12, 8, 8'h5A, 1'b0);
    repeat (5) @(posedge clk);
    #1 check("word_1234", {16'd0, rx_word}, 32'h1234);

    for (int i = 0; i < 8; i++) begin
      sclk = ~sclk;
      mosi = i[0];
      repeat (20) @(posedge clk);
      #1 check("miso_idle", {31'd0, miso}, 32'd0);
    end
    sclk = 1'b0;

    spi_frame(8'hC3, 5, 8'h81, 1'b0);
    spi_frame(8'h34, 8, 8'h3C, 1'b0);
    spi_frame(8'h12, 8, 8'hF0, 1'b0);
    repeat (5) @(posedge clk);
    #1 check("word_realigned", {16'd0, rx_word}, 32'h1234);

    spi_frame(8'h77, 8, 8'h00, 1'b0);
    cs = 1'b0;
    mosi = 1'b1;
    repeat (20) @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      sclk = 1'b1; repeat (50) @(posedge clk);
      sclk = 1'b0; repeat (50) @(posedge clk);
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    rst_n = 1'b1;
    void'(byte_q.pop_back());
    exp_phase = 1'b0;
    #1 check("midreset_rx_word", {16'd0, rx_word}, 32'd0);
    repeat (20) @(posedge clk);
    cs = 1'b1;
    repeat (20) @(posedge clk);

    spi_frame(8'hFF, 8, 8'h96, 1'b0);
    spi_frame(8'h00, 8, 8'h69, 1'b0);
    repeat (20) @(posedge clk);
    #1 check("word_00ff", {16'd0, rx_word}, 32'h00FF);

    check("byte_q_drained", byte_q.size(), 32'd0);
    check("word_q_drained", word_q.size(), 32'd0);
    check("err_q_drained", err_q.size(), 32'd0);
    check("frame_err_count", n_err_seen, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
